instr_reg_sched: RTL and testbench

Write/read scheduler for the 32-entry instruction register. Two write requesters share the register's single write port through round-robin arbitration. Accepted instructions are placed in ring order. The block then reads them back in the same order onto a valid/ready output stream. It sits between the stimulus/host agents and instr_register, and drives all of that register's control and data inputs.

---
 rtl/instr_register_pkg.sv | 45 ++++
 rtl/instr_rr_arb2.sv | 30 +++
 rtl/instr_reg_sched.sv | 164 ++++++++++++++++
 tb/tb_instr_reg_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared types, scheduler state and result helper for instr_register
package instr_register_pkg;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t            opc;
    operand_t           op_a;
    operand_t           op_b;
    logic signed [63:0] result;
  } instruction_t;

  // Copy of what was written, kept by the optional result checker
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } shadow_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL, FLUSH} sched_state_t;

  localparam int SCHED_DEPTH = 32;

  // Reference result: signed, sign-extended to 64 bits; divide/modulo by zero yield 0
  function automatic logic signed [63:0] calc_result(opcode_t opc, operand_t a, operand_t b);
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    a64 = a;
    b64 = b;
    case (opc)
      ZERO:    return '0;
      PASSA:   return a64;
      PASSB:   return b64;
      ADD:     return a64 + b64;
      SUB:     return a64 - b64;
      MULT:    return a64 * b64;
      DIV:     return (b == 0) ? '0 : a64 / b64;
      MOD:     return (b == 0) ? '0 : a64 % b64;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_rr_arb2.sv
// rtl/instr_rr_arb2.sv - 2-way round-robin arbiter, requester A wins first after reset
module instr_rr_arb2
  import instr_register_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_last_b;

  // Grant the sole requester, or the one not served last when both ask
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_valid == 2'b11) o_grant = r_last_b ? 2'b01 : 2'b10;
      else                  o_grant = i_valid;
    end
  end

  // A grant is always an accept, so remember who was just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_last_b <= 1'b1;
    else if (o_grant[0]) r_last_b <= 1'b0;
    else if (o_grant[1]) r_last_b <= 1'b1;
  end

endmodule

// File: rtl/instr_reg_sched.sv
// rtl/instr_reg_sched.sv - write/read scheduler for instr_register; optional RESULT_CHECK_EN adds chk_err
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH = SCHED_DEPTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               a_valid,
  output logic               a_ready,
  input  opcode_t            a_opcode,
  input  operand_t           a_operand_a,
  input  operand_t           a_operand_b,
  input  logic               b_valid,
  output logic               b_ready,
  input  opcode_t            b_opcode,
  input  operand_t           b_operand_a,
  input  operand_t           b_operand_b,
  output logic               reg_reset_n,
  output logic               load_en,
  output address_t           write_pointer,
  output address_t           read_pointer,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  input  instruction_t       instruction_word,
`ifdef RESULT_CHECK_EN
  output logic               chk_err,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  sched_state_t     r_state;
  address_t         r_wr_ptr;
  address_t         r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  instruction_t     r_out_data;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_en  = !w_full && (r_state != FLUSH) && !flush;
  assign w_accept = |w_grant;
  assign w_pop    = !w_empty && (!r_out_valid || out_ready) && (r_state != FLUSH) && !flush;
  assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

  instr_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_wr_en),
    .i_valid ({b_valid, a_valid}),
    .o_grant (w_grant)
  );

  assign a_ready       = w_grant[0];
  assign b_ready       = w_grant[1];
  assign load_en       = w_accept;
  assign reg_reset_n   = ~reset;
  assign write_pointer = r_wr_ptr;
  assign read_pointer  = r_rd_ptr;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;

  // Register write data comes from the granted requester, zero when idle
  always_comb begin
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;
    if (w_grant[0]) begin
      opcode    = a_opcode;
      operand_a = a_operand_a;
      operand_b = a_operand_b;
    end else if (w_grant[1]) begin
      opcode    = b_opcode;
      operand_a = b_operand_a;
      operand_b = b_operand_b;
    end
  end

  // Ring pointers, occupancy, output stage and scheduler state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_state     <= FLUSH;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_out_data  <= instruction_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_count <= w_count_nxt;
      case (r_state)
        IDLE:    if (w_accept) r_state <= ACTIVE;
        ACTIVE:  if (w_count_nxt == CNT_W'(DEPTH)) r_state <= FULL;
                 else if (w_count_nxt == '0)       r_state <= IDLE;
        FULL:    if (w_pop) r_state <= ACTIVE;
        FLUSH:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_CHECK_EN
  shadow_t r_shadow [DEPTH];
  shadow_t w_sh;
  logic    w_mismatch;
  logic    r_chk_err;

  assign w_sh    = r_shadow[r_rd_ptr];
  assign chk_err = r_chk_err;

  always_comb begin
    w_mismatch = (instruction_word.result !== calc_result(w_sh.opc, w_sh.op_a, w_sh.op_b)) ||
                 (instruction_word.opc    !== w_sh.opc)  ||
                 (instruction_word.op_a   !== w_sh.op_a) ||
                 (instruction_word.op_b   !== w_sh.op_b);
  end

  // Keep our own copy of every accepted instruction at its ring slot
  always_ff @(posedge clk) begin
    if (w_accept) r_shadow[r_wr_ptr] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
  end

  // Error flag travels with out_data and drops whenever out_valid drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_chk_err <= 1'b0;
    else if (flush)     r_chk_err <= 1'b0;
    else if (w_pop)     r_chk_err <= w_mismatch;
    else if (out_ready) r_chk_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_instr_reg_sched.sv
// tb/tb_instr_reg_sched.sv - directed self-checking bench for instr_reg_sched
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush;
  logic         a_valid, a_ready, b_valid, b_ready;
  opcode_t      a_opcode, b_opcode, opcode;
  operand_t     a_operand_a, a_operand_b, b_operand_a, b_operand_b, operand_a, operand_b;
  logic         reg_reset_n, load_en;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word, out_data;
  logic         out_valid, out_ready;
  logic [5:0]   count;
  logic         full, empty;
`ifdef RESULT_CHECK_EN
  logic         chk_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic corrupt = 1'b0;
  instruction_t mem [32];

  always #5 clk = ~clk;

  instr_reg_sched dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_operand_a(a_operand_a), .a_operand_b(a_operand_b),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode),
    .b_operand_a(b_operand_a), .b_operand_b(b_operand_b),
    .reg_reset_n(reg_reset_n), .load_en(load_en),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .instruction_word(instruction_word),
`ifdef RESULT_CHECK_EN
    .chk_err(chk_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  // Behavioural instr_register: write on load_en, combinational read
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b, calc_result(opcode, operand_a, operand_b)};
  end

  always_comb begin
    instruction_word = mem[read_pointer];
    if (corrupt) instruction_word.result = instruction_word.result + 64'sd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    flush = 0; out_ready = 0;
    a_valid = 0; a_opcode = ZERO; a_operand_a = 0; a_operand_b = 0;
    b_valid = 0; b_opcode = ZERO; b_operand_a = 0; b_operand_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset = 1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty, full); end
    n_vec++; if (reg_reset_n !== 1'b0) begin n_err++; $display("FAIL reset_reg_reset_n got %0b exp 0", reg_reset_n); end
    n_vec++; if (out_data !== instruction_t'(0)) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    step();
    reset = 0;
    #1;
    n_vec++; if (reg_reset_n !== 1'b1) begin n_err++; $display("FAIL release_reg_reset_n got %0b exp 1", reg_reset_n); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    a_valid = 1; a_opcode = ADD; a_operand_a = 1; a_operand_b = 1;
    repeat (6) step();
    a_valid = 0;
    #1;
    n_vec++; if (count !== 6'd5 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_setup got count=%0d ov=%0b exp 5/1", count, out_valid); end
    reset = 1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin n_err++; $display("FAIL mid_async_reset got ov=%0b count=%0d empty=%0b exp 0/0/1", out_valid, count, empty); end
    step();
    reset = 0;
    a_valid = 1;
    #1;
    n_vec++; if (a_ready !== 1'b1 || write_pointer !== 5'd0) begin n_err++; $display("FAIL mid_next_addr got rdy=%0b wp=%0d exp 1/0", a_ready, write_pointer); end
    step();
    a_valid = 0;
  endtask

  task automatic test_a_only();
    opcode_t opc [3] = '{ADD, SUB, MULT};
    int      oa  [3] = '{5, 2, -4};
    int      ob  [3] = '{3, 7, 6};
    longint  ex  [3] = '{8, -5, -24};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_opcode = opc[i]; a_operand_a = oa[i]; a_operand_b = ob[i];
      #1;
      n_vec++; if (a_ready !== 1'b1 || write_pointer !== address_t'(i)) begin n_err++; $display("FAIL aonly_wr%0d got rdy=%0b wp=%0d exp 1/%0d", i, a_ready, write_pointer, i); end
      step();
      if (i == 0) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL aonly_latency got ov=%0b exp 0 after first edge", out_valid); end
      end else begin
        n_vec++; if (out_valid !== 1'b1 || out_data.result !== ex[i-1] || out_data.opc !== opc[i-1]) begin n_err++; $display("FAIL aonly_out%0d got ov=%0b res=%0d exp 1/%0d", i-1, out_valid, out_data.result, ex[i-1]); end
      end
    end
    a_valid = 0;
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data.result !== ex[2] || out_data.opc !== MULT) begin n_err++; $display("FAIL aonly_out2 got ov=%0b res=%0d exp 1/%0d", out_valid, out_data.result, ex[2]); end
    step();
    n_vec++; if (out_valid !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL aonly_drain got ov=%0b empty=%0b exp 0/1", out_valid, empty); end
    out_ready = 0;
  endtask

  task automatic test_rr_full();
    do_reset();
    a_valid = 1; a_opcode = PASSA; a_operand_a = 100; a_operand_b = 101;
    b_valid = 1; b_opcode = PASSB; b_operand_a = 200; b_operand_b = 201;
    // 32 slots in the ring plus one entry parked in out_data
    for (int i = 0; i < 33; i++) begin
      logic ea;
      ea = (i % 2 == 0);
      #1;
      n_vec++; if (a_ready !== ea || b_ready !== !ea || write_pointer !== address_t'(i % 32)) begin n_err++; $display("FAIL rr_grant%0d got a=%0b b=%0b wp=%0d exp %0b/%0b/%0d", i, a_ready, b_ready, write_pointer, ea, !ea, i % 32); end
      step();
    end
    #1;
    n_vec++; if (full !== 1'b1 || count !== 6'd32 || a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL rr_full got full=%0b count=%0d a=%0b b=%0b exp 1/32/0/0", full, count, a_ready, b_ready); end
    step();
    n_vec++; if (a_ready !== 1'b0 || out_data.op_a !== 100) begin n_err++; $display("FAIL rr_stall got a=%0b opa=%0d exp 0/100", a_ready, out_data.op_a); end
    out_ready = 1;
    step();
    out_ready = 0;
    #1;
    n_vec++; if (out_data.op_a !== 200 || count !== 6'd31) begin n_err++; $display("FAIL rr_pop got opa=%0d count=%0d exp 200/31", out_data.op_a, count); end
    n_vec++; if (b_ready !== 1'b1 || a_ready !== 1'b0 || write_pointer !== 5'd1) begin n_err++; $display("FAIL rr_wrap got a=%0b b=%0b wp=%0d exp 0/1/1", a_ready, b_ready, write_pointer); end
    step();
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_simul();
    do_reset();
    a_valid = 1; a_opcode = SUB; a_operand_a = 9; a_operand_b = 4;
    repeat (11) step();
    #1;
    n_vec++; if (count !== 6'd10 || write_pointer !== 5'd11 || read_pointer !== 5'd1) begin n_err++; $display("FAIL simul_setup got count=%0d wp=%0d rp=%0d exp 10/11/1", count, write_pointer, read_pointer); end
    out_ready = 1;
    step();
    a_valid = 0; out_ready = 0;
    #1;
    n_vec++; if (count !== 6'd10 || write_pointer !== 5'd12 || read_pointer !== 5'd2) begin n_err++; $display("FAIL simul_both got count=%0d wp=%0d rp=%0d exp 10/12/2", count, write_pointer, read_pointer); end
  endtask

  task automatic test_flush();
    do_reset();
    a_valid = 1; a_opcode = ADD; a_operand_a = 3; a_operand_b = 4;
    repeat (8) step();
    #1;
    n_vec++; if (count !== 6'd7 || out_valid !== 1'b1) begin n_err++; $display("FAIL flush_setup got count=%0d ov=%0b exp 7/1", count, out_valid); end
    flush = 1;
    #1;
    n_vec++; if (a_ready !== 1'b0 || load_en !== 1'b0) begin n_err++; $display("FAIL flush_cycle got rdy=%0b load=%0b exp 0/0", a_ready, load_en); end
    step();
    flush = 0;
    #1;
    n_vec++; if (count !== 6'd0 || out_valid !== 1'b0 || a_ready !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_state got count=%0d ov=%0b rdy=%0b empty=%0b exp 0/0/0/1", count, out_valid, a_ready, empty); end
    step();
    #1;
    n_vec++; if (a_ready !== 1'b1 || write_pointer !== 5'd0) begin n_err++; $display("FAIL flush_resume got rdy=%0b wp=%0d exp 1/0", a_ready, write_pointer); end
    step();
    a_valid = 0;
  endtask

`ifdef RESULT_CHECK_EN
  task automatic test_chk();
    do_reset();
    out_ready = 1;
    a_valid = 1; a_opcode = DIV; a_operand_a = 9; a_operand_b = 0;
    step();
    a_valid = 0;
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data.result !== 64'sd0 || chk_err !== 1'b0) begin n_err++; $display("FAIL chk_div0 got ov=%0b res=%0d err=%0b exp 1/0/0", out_valid, out_data.result, chk_err); end
    step();
    corrupt = 1;
    a_valid = 1; a_opcode = ADD; a_operand_a = 1; a_operand_b = 2;
    step();
    a_valid = 0;
    step();
    n_vec++; if (out_valid !== 1'b1 || chk_err !== 1'b1) begin n_err++; $display("FAIL chk_bad got ov=%0b err=%0b exp 1/1", out_valid, chk_err); end
    corrupt = 0;
    step();
    n_vec++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clear got err=%0b exp 0", chk_err); end
    out_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midstream();
    test_a_only();
    test_rr_full();
    test_simul();
    test_flush();
`ifdef RESULT_CHECK_EN
    test_chk();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
